bn_requant: RTL and testbench
=============================

# bn_requant

Per-channel folded batch-norm and requantization stage for the bottleneck layer. It sits directly upstream of the ReLU stage and feeds it with the same `data / channel / valid` stream format. Each sample is multiplied by a per-channel fixed-point scale, has a per-channel bias added, and is then rounded, shifted and saturated back to N bits. Scale and bias tables are loaded through a simple write port and may be rewritten while streaming.

## Interface
- N, 16, data width of samples in and out (signed two's complement)
- CHANNELS, 16, number of channels; table depth
- SCALE_W, 16, scale width (signed)
- FRAC, 8, fractional bits of scale (scale 1.0 = 1<<FRAC); FRAC ≥ 1
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(CHANNELS)  channel index to write
- cfg_scale  in  SCALE_W  signed scale for cfg_addr
- cfg_bias  in  N  signed bias for cfg_addr, in output units
- data_in  in  N  signed input sample
- channel_in  in  $clog2(CHANNELS)  channel of data_in
- valid_in  in  1  data_in/channel_in qualify this cycle
- data_out  out  N  signed requantized sample
- channel_out  out  $clog2(CHANNELS)  channel of data_out
- valid_out  out  1  data_out/channel_out qualify this cycle

## Operation
- Tables: scale_tab[CHANNELS], bias_tab[CHANNELS]. Reset loads every entry with scale = 1<<FRAC and bias = 0, so the block is identity after reset.
- Write: on a clock edge with cfg_we=1, scale_tab[cfg_addr] and bias_tab[cfg_addr] are both updated. cfg_addr ≥ CHANNELS is ignored.
- Stage 1 (register):
  - Latch data_in, channel_in and valid_in.
  - Read scale/bias for channel_in; the read returns the table content before any same-cycle write.
- Stage 2 (multiply):
  - prod = signed(data) × signed(scale), width N+SCALE_W.
  - Carry bias, channel and valid forward.
- Stage 3 (add / shift / saturate):
  - acc = prod + (sign-extended bias <<< FRAC) + (1<<(FRAC-1)), width N+SCALE_W+2.
  - res = acc >>> FRAC (arithmetic shift). Rounding is therefore round-half-up (toward +∞).
  - Clamp res to [−2^(N−1), 2^(N−1)−1], then register to data_out.
- Output qualification:
  - Sample with valid=1: valid_out=1, channel_out = its channel.
  - Pipeline slot with valid=0: data_out=0, channel_out=0, valid_out=0. The ReLU stage relies on zeroed idle outputs.
- No backpressure. The block accepts one sample per cycle unconditionally; back-to-back valid samples, including mixed channels, are required to work.

## Timing
- Latency: a sample on valid_in at edge t appears on valid_out after edge t+3. Throughput is 1 sample per cycle.
- Table write at edge t:
  - Affects samples captured at edge t+1 or later.
  - A sample captured at edge t uses the old value.
  - Samples already in stage 2/3 are unaffected.
- Reset value of every output: data_out=0, channel_out=0, valid_out=0. All pipeline valids are cleared.
- Reset mid-stream:
  - In-flight samples are discarded; valid_out=0 from the edge where rst is sampled high.
  - Tables return to identity.
  - First sample after rst drops is output 3 cycles after capture.
- cfg_we while rst=1 is ignored; reset wins.

## Test plan
- Identity after reset: valid samples 5, −7, 32767, −32768 on channels 0..3 → the same values on data_out with matching channel_out, exactly 3 cycles later, valid_out=0 in idle cycles with data_out=0.
- Scale and rounding: ch2 scale=0x0080 (0.5), bias 0; inputs 3, −3, 1 → outputs 2, −1, 1 (round-half-up).
- Saturation: ch1 scale=0x0200 (2.0); inputs 20000, −20000, 100 → 32767, −32768, 200.
- Bias: ch4 scale=0x0100, bias=100; inputs 10, −150 → 110, −50. Ch4 bias=−32768 with input −1 → −32768 (saturated).
- Write/stream collision: stream ch3 every cycle; write ch3 scale=0x0200 at edge t → sample captured at t uses old scale 1.0, sample at t+1 doubled; other channels unchanged.
- Reset mid-stream: 3 samples in flight, assert rst one cycle → no valid_out for those samples, tables back to identity, next sample 9 on ch0 → 9 three cycles later.

Source files
------------

// File: rtl/bn_requant.sv
// bn_requant
// Per-channel folded batch-norm and requantization stage. Each valid sample
// is multiplied by a per-channel signed fixed-point scale. A per-channel bias
// is added and the sum is rounded half-up. The result is shifted back by FRAC
// and saturated to N bits. Scale/bias tables are written through a simple
// config port and may be rewritten while samples are streaming.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   cfg_we        table write strobe
//   cfg_addr      channel whose scale/bias entry is written
//   cfg_scale     signed scale, FRAC fractional bits
//   cfg_bias      signed bias in output units
//   data_in       signed input sample
//   channel_in    channel of data_in
//   valid_in      qualifies data_in/channel_in
//   data_out      signed requantized sample (zero when not valid)
//   channel_out   channel of data_out (zero when not valid)
//   valid_out     qualifies data_out/channel_out
//
// Latency is 3 cycles from capture: input/table-read register, product
// register, shifted-sum register, then the saturated output register.
module bn_requant #(
  parameter int N        = 16,
  parameter int CHANNELS = 16,
  parameter int SCALE_W  = 16,
  parameter int FRAC     = 8,
  parameter int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [SCALE_W-1:0]  cfg_scale,
  input  logic [N-1:0]        cfg_bias,
  input  logic [N-1:0]        data_in,
  input  logic [AW-1:0]       channel_in,
  input  logic                valid_in,
  output logic [N-1:0]        data_out,
  output logic [AW-1:0]       channel_out,
  output logic                valid_out
);

  localparam int PW   = N + SCALE_W;
  localparam int ACCW = PW + 2;

  localparam logic [SCALE_W-1:0]    SCALE_ONE = SCALE_W'(1) << FRAC;
  localparam logic signed [ACCW-1:0] ROUND_HALF = ACCW'(1) << (FRAC - 1);
  localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic [SCALE_W-1:0] scale_tab_q [CHANNELS];
  logic [N-1:0]       bias_tab_q  [CHANNELS];

  logic signed [N-1:0]       data1_q;
  logic signed [SCALE_W-1:0] scale1_q;
  logic signed [N-1:0]       bias1_q;
  logic [AW-1:0]             chan1_q;
  logic                      valid1_q;

  logic signed [PW-1:0]      prod_d;
  logic signed [PW-1:0]      prod2_q;
  logic signed [N-1:0]       bias2_q;
  logic [AW-1:0]             chan2_q;
  logic                      valid2_q;

  logic signed [ACCW-1:0]    acc_d;
  logic signed [ACCW-1:0]    res_d;
  logic signed [ACCW-1:0]    res3_q;
  logic [AW-1:0]             chan3_q;
  logic                      valid3_q;

  logic [N-1:0]              sat_d;
  logic [N-1:0]              data_out_q;
  logic [AW-1:0]             chan_out_q;
  logic                      valid_out_q;

  // Coefficient tables. Reset restores identity (scale 1.0, bias 0) and takes
  // priority over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        scale_tab_q[i] <= SCALE_ONE;
        bias_tab_q[i]  <= '0;
      end
    end else if (cfg_we && (32'(cfg_addr) < CHANNELS)) begin
      scale_tab_q[cfg_addr] <= cfg_scale;
      bias_tab_q[cfg_addr]  <= cfg_bias;
    end
  end

  // Stage 1: capture the sample and read its coefficients. The read sees the
  // table before a write on the same edge, so a colliding write only affects
  // later samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      data1_q  <= '0;
      scale1_q <= '0;
      bias1_q  <= '0;
      chan1_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      data1_q  <= data_in;
      scale1_q <= scale_tab_q[channel_in];
      bias1_q  <= bias_tab_q[channel_in];
      chan1_q  <= channel_in;
      valid1_q <= valid_in;
    end
  end

  assign prod_d = PW'(data1_q) * PW'(scale1_q);

  // Stage 2: full-width signed product.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod2_q  <= '0;
      bias2_q  <= '0;
      chan2_q  <= '0;
      valid2_q <= 1'b0;
    end else begin
      prod2_q  <= prod_d;
      bias2_q  <= bias1_q;
      chan2_q  <= chan1_q;
      valid2_q <= valid1_q;
    end
  end

  // Bias is aligned to the product's binary point. Adding half an LSB before
  // the arithmetic shift gives round-half-up.
  always_comb begin
    acc_d = ACCW'(prod2_q) + (ACCW'(bias2_q) <<< FRAC) + ROUND_HALF;
    res_d = acc_d >>> FRAC;
  end

  // Stage 3: rounded and shifted result, still at full width for saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      res3_q   <= '0;
      chan3_q  <= '0;
      valid3_q <= 1'b0;
    end else begin
      res3_q   <= res_d;
      chan3_q  <= chan2_q;
      valid3_q <= valid2_q;
    end
  end

  always_comb begin
    sat_d = res3_q[N-1:0];
    if (res3_q > MAX_V) begin
      sat_d = MAX_V[N-1:0];
    end else if (res3_q < MIN_V) begin
      sat_d = MIN_V[N-1:0];
    end
  end

  // Output register. Idle slots drive all-zero so the downstream stage can
  // rely on clean outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      chan_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      data_out_q  <= valid3_q ? sat_d : '0;
      chan_out_q  <= valid3_q ? chan3_q : '0;
      valid_out_q <= valid3_q;
    end
  end

  assign data_out    = data_out_q;
  assign channel_out = chan_out_q;
  assign valid_out   = valid_out_q;

endmodule

// File: tb/tb_bn_requant.sv
// tb_bn_requant
// Directed bench for bn_requant. Each call of applyStimulus drives one cycle
// of inputs together with the hand-computed result for that cycle's sample.
// The expected result enters a 3-deep delay line. After every edge the
// outputs are compared against the entry that was captured three edges
// earlier.
module tb_bn_requant;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_scale;
  logic [15:0] cfg_bias;
  logic [15:0] data_in;
  logic [3:0]  channel_in;
  logic        valid_in;
  logic [15:0] data_out;
  logic [3:0]  channel_out;
  logic        valid_out;

  int checks;
  int errors;

  logic        expValid [4];
  logic [15:0] expData  [4];
  logic [3:0]  expChan  [4];
  string       expTag   [4];

  bn_requant dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_scale   (cfg_scale),
    .cfg_bias    (cfg_bias),
    .data_in     (data_in),
    .channel_in  (channel_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .channel_out (channel_out),
    .valid_out   (valid_out)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs and step the delay line of expected results.
  // Then check the outputs one time unit after the edge. A reset cycle flushes
  // the line, because reset discards everything still in flight.
  task automatic applyStimulus(input logic r, input logic we, input logic [3:0] wa,
                               input logic [15:0] ws, input logic [15:0] wb,
                               input logic v, input logic [3:0] ch, input logic [15:0] d,
                               input logic [15:0] expD, input string tag);
    rst        = r;
    cfg_we     = we;
    cfg_addr   = wa;
    cfg_scale  = ws;
    cfg_bias   = wb;
    valid_in   = v;
    channel_in = ch;
    data_in    = d;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        expValid[i] = 1'b0;
        expData[i]  = '0;
        expChan[i]  = '0;
        expTag[i]   = "reset";
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        expValid[i] = expValid[i-1];
        expData[i]  = expData[i-1];
        expChan[i]  = expChan[i-1];
        expTag[i]   = expTag[i-1];
      end
      expValid[0] = v;
      expData[0]  = v ? expD : 16'h0000;
      expChan[0]  = v ? ch : 4'h0;
      expTag[0]   = v ? tag : "idle";
    end
    checkOutput({expTag[3], ".valid"}, 32'(valid_out), 32'(expValid[3]));
    checkOutput({expTag[3], ".data"}, 32'(data_out), 32'(expData[3]));
    checkOutput({expTag[3], ".chan"}, 32'(channel_out), 32'(expChan[3]));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, "idle");
    end
  endtask

  task automatic sample(input logic [3:0] ch, input logic [15:0] d, input logic [15:0] expD, input string tag);
    applyStimulus(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, ch, d, expD, tag);
  endtask

  task automatic writeCfg(input logic [3:0] wa, input logic [15:0] ws, input logic [15:0] wb);
    applyStimulus(1'b0, 1'b1, wa, ws, wb, 1'b0, 4'h0, 16'h0, 16'h0, "cfg");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) begin
      expValid[i] = 1'b0;
      expData[i]  = '0;
      expChan[i]  = '0;
      expTag[i]   = "init";
    end

    // Reset: all outputs zero.
    applyStimulus(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, "reset");
    applyStimulus(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, "reset");
    idleCycles(2);

    // Identity after reset, back to back on channels 0..3.
    sample(4'd0, 16'd5,       16'd5,       "id_5");
    sample(4'd1, -16'sd7,     -16'sd7,     "id_m7");
    sample(4'd2, 16'h7FFF,    16'h7FFF,    "id_max");
    sample(4'd3, 16'h8000,    16'h8000,    "id_min");
    idleCycles(4);

    // Scale 0.5 on ch2: round-half-up.
    writeCfg(4'd2, 16'h0080, 16'h0000);
    sample(4'd2, 16'd3,       16'd2,       "half_3");
    sample(4'd2, -16'sd3,     -16'sd1,     "half_m3");
    sample(4'd2, 16'd1,       16'd1,       "half_1");
    idleCycles(4);

    // Scale 2.0 on ch1: saturation both ways.
    writeCfg(4'd1, 16'h0200, 16'h0000);
    sample(4'd1, 16'd20000,   16'h7FFF,    "sat_pos");
    sample(4'd1, -16'sd20000, 16'h8000,    "sat_neg");
    sample(4'd1, 16'd100,     16'd200,     "dbl_100");
    idleCycles(4);

    // Bias on ch4, including negative saturation driven by the bias.
    writeCfg(4'd4, 16'h0100, 16'd100);
    sample(4'd4, 16'd10,      16'd110,     "bias_10");
    sample(4'd4, -16'sd150,   -16'sd50,    "bias_m150");
    writeCfg(4'd4, 16'h0100, 16'h8000);
    sample(4'd4, -16'sd1,     16'h8000,    "bias_sat");
    idleCycles(4);

    // Write/stream collision on ch3: same-edge sample uses the old scale.
    sample(4'd3, 16'd1000,    16'd1000,    "col_pre");
    applyStimulus(1'b0, 1'b1, 4'd3, 16'h0200, 16'h0000, 1'b1, 4'd3, 16'd1000, 16'd1000, "col_same");
    sample(4'd3, 16'd1000,    16'd2000,    "col_next");
    sample(4'd0, 16'd7,       16'd7,       "col_other");
    sample(4'd3, -16'sd4,     -16'sd8,     "col_neg");
    idleCycles(4);

    // Reset mid-stream with a write on the reset cycle that must be ignored.
    writeCfg(4'd0, 16'h0300, 16'h0000);
    sample(4'd0, 16'd1,       16'd3,       "flight_1");
    sample(4'd0, 16'd2,       16'd6,       "flight_2");
    sample(4'd0, 16'd3,       16'd9,       "flight_3");
    applyStimulus(1'b1, 1'b1, 4'd0, 16'h0400, 16'h0000, 1'b1, 4'd0, 16'd4, 16'd0, "reset");
    sample(4'd0, 16'd9,       16'd9,       "post_rst");
    sample(4'd2, 16'd3,       16'd3,       "post_rst_ch2");
    idleCycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
